// File: rtl/router_pkg.sv
// Shared types and helpers for the parametrised packet router.
package router_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DROP} state_t;

  localparam int unsigned DEF_DW      = 8;
  localparam int unsigned DEF_NCH     = 3;
  localparam int unsigned DEF_AW      = 2;
  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 30;
  localparam int unsigned DEF_PTR_W   = $clog2(DEF_DEPTH);

  // Header layout is {len, addr}; addr occupies the low aw bits.
  function automatic int unsigned hdr_addr(input logic [31:0] w, input int unsigned aw);
    return w & ((32'd1 << aw) - 32'd1);
  endfunction

  function automatic int unsigned hdr_len(input logic [31:0] w, input int unsigned aw);
    return w >> aw;
  endfunction

endpackage

// File: rtl/router_fifo_ch.sv
// One output channel: word FIFO, registered read data and idle-read timeout flush.
module router_fifo_ch #(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_data,
  output logic          o_vld,
  output logic          o_full,
  output logic          o_flush
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW:0]   r_wptr, r_rptr;
  logic [TW-1:0] r_tcnt;
  logic [DW-1:0] r_data;
  logic          w_empty, w_full, w_rd, w_idle, w_flush;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_rd    = i_rd & ~w_empty;
  assign w_idle  = ~w_empty & ~i_rd;
  assign w_flush = w_idle && (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_tcnt <= '0;
      r_data <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_tcnt <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + (PW + 1)'(1);
      if (w_rd) begin
        r_rptr <= r_rptr + (PW + 1)'(1);
        r_data <= r_mem[r_rptr[PW-1:0]];
      end
      r_tcnt <= w_idle ? r_tcnt + TW'(1) : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (i_wr) r_mem[r_wptr[PW-1:0]] <= i_wdata;
  end

  assign o_data  = r_data;
  assign o_vld   = ~w_empty;
  assign o_full  = w_full;
  assign o_flush = w_flush;

endmodule

// File: rtl/router_top_param.sv
// Byte-serial packet router: header/payload/parity framing into NCH buffered channels.
module router_top_param import router_pkg::*; #(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned NCH     = DEF_NCH,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DW-1:0]     data_in,
  input  logic [NCH-1:0]    read_enb,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    vld_out,
  output logic              busy,
  output logic              err
);

  localparam int unsigned LW = DW - AW;

  state_t         r_state, w_next;
  logic [AW-1:0]  r_ch, w_addr, w_sel;
  logic [LW-1:0]  r_len, w_len;
  logic [LW:0]    r_pcnt;
  logic [DW-1:0]  r_par, r_pword;
  logic           r_err;
  logic [NCH-1:0] w_full, w_flush, w_wr;
  logic           w_addr_ok, w_sel_full, w_acc, w_write, w_to;

  assign w_addr     = AW'(hdr_addr(32'(data_in), AW));
  assign w_len      = LW'(hdr_len(32'(data_in), AW));
  assign w_addr_ok  = (32'(w_addr) < NCH);
  assign w_sel      = (r_state == S_IDLE) ? w_addr : r_ch;
  assign w_sel_full = (32'(w_sel) < NCH) ? w_full[w_sel] : 1'b0;
  assign w_to       = w_flush[r_ch];

  assign busy  = (r_state == S_CHECK) |
                 (((r_state == S_IDLE) | (r_state == S_LOAD)) & w_sel_full);
  assign w_acc = ~busy & (r_state != S_CHECK) & ((r_state != S_IDLE) | pkt_valid);

  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_acc) begin
        w_next  = w_addr_ok ? S_LOAD : S_DROP;
        w_write = w_addr_ok;
      end
      S_LOAD: if (w_to) begin
        // Flush of the channel being loaded aborts the packet.
        w_next = (w_acc & ~pkt_valid) ? S_IDLE : S_DROP;
      end else if (w_acc) begin
        w_write = 1'b1;
        if (!pkt_valid) w_next = S_CHECK;
      end
      S_CHECK: w_next = S_IDLE;
      S_DROP:  if (w_acc & ~pkt_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr = '0;
    for (int unsigned c = 0; c < NCH; c++) w_wr[c] = w_write && (32'(w_sel) == c);
  end

  // Payload is counted up and compared with len in CHECK; saturates so overruns never alias.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_len   <= '0;
      r_pcnt  <= '0;
      r_par   <= '0;
      r_pword <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_acc) begin
          if (w_addr_ok) begin
            r_ch   <= w_addr;
            r_len  <= w_len;
            r_pcnt <= '0;
            r_par  <= data_in;
            r_err  <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end
        S_LOAD: if (w_to) begin
          r_err <= 1'b1;
        end else if (w_acc) begin
          if (pkt_valid) begin
            r_par <= r_par ^ data_in;
            if (!(&r_pcnt)) r_pcnt <= r_pcnt + (LW + 1)'(1);
          end else begin
            r_pword <= data_in;
          end
        end
        S_CHECK: r_err <= (r_par != r_pword) | (r_pcnt != {1'b0, r_len});
        default: ;
      endcase
    end
  end

  assign err = r_err;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    router_fifo_ch #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT)
    ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .i_wr   (w_wr[c]),
      .i_wdata(data_in),
      .i_rd   (read_enb[c]),
      .o_data (data_out[c*DW +: DW]),
      .o_vld  (vld_out[c]),
      .o_full (w_full[c]),
      .o_flush(w_flush[c])
    );
  end

endmodule
